// File: rtl/writeback_pkg.sv
// Shared types for the writeback stage: operand-size and stack-op codes, FSM
// state encoding, and small decode helpers used by writeback_top and wb_mem_seq.
package writeback_pkg;

  localparam logic [2:0] OPSIZE_8  = 3'd0;
  localparam logic [2:0] OPSIZE_16 = 3'd1;
  localparam logic [2:0] OPSIZE_32 = 3'd2;
  localparam logic [2:0] OPSIZE_64 = 3'd3;

  localparam logic [1:0] STACK_NONE = 2'b00;
  localparam logic [1:0] STACK_PUSH = 2'b01;
  localparam logic [1:0] STACK_POP  = 2'b10;
  localparam logic [1:0] STACK_RSVD = 2'b11;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_LO = 2'd1,
    ST_MEM_HI = 2'd2
  } wb_state_e;

  // Unlisted size codes behave as 32-bit operands.
  function automatic logic [31:0] opsize_bytes(input logic [2:0] opsize);
    case (opsize)
      OPSIZE_8:  opsize_bytes = 32'd1;
      OPSIZE_16: opsize_bytes = 32'd2;
      OPSIZE_64: opsize_bytes = 32'd8;
      default:   opsize_bytes = 32'd4;
    endcase
  endfunction

  function automatic logic [2:0] mem_size_of(input logic [2:0] opsize);
    if (opsize == OPSIZE_8 || opsize == OPSIZE_16) mem_size_of = opsize;
    else mem_size_of = OPSIZE_32;
  endfunction

  function automatic logic stack_adjusts(input logic [1:0] stack_op);
    stack_adjusts = (stack_op == STACK_PUSH) || (stack_op == STACK_POP);
  endfunction

  function automatic logic [31:0] stack_delta(input logic [2:0] opsize, input logic [1:0] stack_op);
    logic [31:0] bytes;
    bytes = opsize_bytes(opsize);
    case (stack_op)
      STACK_PUSH: stack_delta = 32'd0 - bytes;
      STACK_POP:  stack_delta = bytes;
      default:    stack_delta = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/wb_mem_seq.sv
// Memory write sequencer: issues the low word and, for 64-bit stores, the high
// word at address+4; a flush lets the current beat finish but skips the rest.
module wb_mem_seq
  import writeback_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [31:0] data_lo,
  input  logic [31:0] data_hi,
  input  logic [2:0]  start_size,
  input  logic        is64,
  input  logic        mem_ack,
  output wb_state_e   state,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [2:0]  mem_size,
  output logic        done
);

  logic        is64_q;
  logic        flushed_q;
  logic [31:0] data_hi_q;
  logic        kill;

  assign kill = flush || flushed_q;

  // Final, unflushed acknowledge of the store; combinational so the stack
  // adjust lands in the same cycle as the ack.
  assign done = !reset && mem_ack && !kill &&
                ((state == ST_MEM_HI) || (state == ST_MEM_LO && !is64_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_data  <= 32'd0;
      mem_size  <= 3'd0;
      is64_q    <= 1'b0;
      flushed_q <= 1'b0;
      data_hi_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_MEM_LO;
            mem_req   <= 1'b1;
            mem_addr  <= start_addr;
            mem_data  <= data_lo;
            mem_size  <= start_size;
            is64_q    <= is64;
            data_hi_q <= data_hi;
            flushed_q <= 1'b0;
          end
        end
        ST_MEM_LO: begin
          if (flush) flushed_q <= 1'b1;
          if (mem_ack) begin
            if (is64_q && !kill) begin
              state    <= ST_MEM_HI;
              mem_addr <= mem_addr + WORD_BYTES;
              mem_data <= data_hi_q;
            end else begin
              state   <= ST_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        ST_MEM_HI: begin
          if (flush) flushed_q <= 1'b1;
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/writeback_top.sv
// Writeback pipestage: retires register/segment/MMX writes, memory stores,
// stack-pointer adjusts and system hand-offs. WB_RETIRE_COUNT_EN adds retire_count.
module writeback_top
  import writeback_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_dest_address,
  input  logic [31:0] wb_dest_reg,
  input  logic [63:0] wb_result,
  input  logic [2:0]  wb_opsize,
  input  logic [15:0] wb_opcode,
  input  logic        wb_op_a_is_address,
  input  logic        wb_op_a_is_reg,
  input  logic        wb_op_a_is_segment,
  input  logic        wb_op_a_is_mmx,
  input  logic        wb_stack,
  input  logic [1:0]  wb_stack_op,
  input  logic        wb_to_sys_controller,
  input  logic [31:0] wb_pc,
  output logic        reg_wr_en,
  output logic [2:0]  reg_wr_idx,
  output logic [31:0] reg_wr_data,
  output logic [2:0]  reg_wr_size,
  output logic        seg_wr_en,
  output logic [2:0]  seg_wr_idx,
  output logic [15:0] seg_wr_data,
  output logic        mmx_wr_en,
  output logic [2:0]  mmx_wr_idx,
  output logic [63:0] mmx_wr_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [2:0]  mem_size,
  input  logic        mem_ack,
  output logic        esp_wr_en,
  output logic [31:0] esp_delta,
  output logic        sys_req,
  output logic [31:0] sys_pc,
  output wb_state_e   dbg_state
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0] retire_count
`endif
);

  wb_state_e state;
  logic      transfer;
  logic      is_sys;
  logic      is_mem;
  logic      is_arch;
  logic      mem_done;
  logic      esp_pulse;
  logic      mem_stack_q;
  logic      unused_inputs;

  assign unused_inputs = ^{wb_dest_reg[31:3], wb_opcode, wb_stack};

  // Handshake: a transfer happens on a rising edge where wb_valid and wb_ready
  // are both high; wb_ready is high only while idle and out of reset, and a
  // same-cycle flush discards the offered transfer.
  assign wb_ready  = (state == ST_IDLE) && !reset;
  assign transfer  = wb_valid && wb_ready && !flush;
  assign is_sys    = wb_to_sys_controller;
  assign is_mem    = !is_sys && wb_op_a_is_address;
  assign is_arch   = !is_sys && !is_mem;
  assign dbg_state = state;
  assign esp_wr_en = esp_pulse || (mem_done && mem_stack_q);

  wb_mem_seq u_mem_seq (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .start      (transfer && is_mem),
    .start_addr (wb_dest_address),
    .data_lo    (wb_result[31:0]),
    .data_hi    (wb_result[63:32]),
    .start_size (mem_size_of(wb_opsize)),
    .is64       (wb_opsize == OPSIZE_64),
    .mem_ack    (mem_ack),
    .state      (state),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_size   (mem_size),
    .done       (mem_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_wr_en   <= 1'b0;
      reg_wr_idx  <= 3'd0;
      reg_wr_data <= 32'd0;
      reg_wr_size <= 3'd0;
      seg_wr_en   <= 1'b0;
      seg_wr_idx  <= 3'd0;
      seg_wr_data <= 16'd0;
      mmx_wr_en   <= 1'b0;
      mmx_wr_idx  <= 3'd0;
      mmx_wr_data <= 64'd0;
      esp_pulse   <= 1'b0;
      esp_delta   <= 32'd0;
      mem_stack_q <= 1'b0;
      sys_req     <= 1'b0;
      sys_pc      <= 32'd0;
    end else begin
      reg_wr_en <= 1'b0;
      seg_wr_en <= 1'b0;
      mmx_wr_en <= 1'b0;
      sys_req   <= 1'b0;
      esp_pulse <= 1'b0;
      if (transfer) begin
        reg_wr_en   <= is_arch && wb_op_a_is_reg;
        seg_wr_en   <= is_arch && wb_op_a_is_segment;
        mmx_wr_en   <= is_arch && wb_op_a_is_mmx;
        sys_req     <= is_sys;
        esp_pulse   <= is_arch && stack_adjusts(wb_stack_op);
        reg_wr_idx  <= wb_dest_reg[2:0];
        reg_wr_data <= wb_result[31:0];
        reg_wr_size <= wb_opsize;
        seg_wr_idx  <= wb_dest_reg[2:0];
        seg_wr_data <= wb_result[15:0];
        mmx_wr_idx  <= wb_dest_reg[2:0];
        mmx_wr_data <= wb_result;
        if (is_sys) sys_pc <= wb_pc;
        if (!is_sys) esp_delta <= stack_delta(wb_opsize, wb_stack_op);
        if (is_mem) mem_stack_q <= stack_adjusts(wb_stack_op);
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic retire_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_pulse <= 1'b0;
      retire_count <= 32'd0;
    end else begin
      retire_pulse <= transfer && !is_mem;
      if (retire_pulse || mem_done) retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_top.sv
// Bench for writeback_top: reset checks, a vector table of single-cycle ops,
// directed memory/flush/reset sequences, and randomized traffic against a model.
module tb_writeback_top;
  import writeback_pkg::*;

  localparam int W = 104;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [31:0] wb_dest_address = '0;
  logic [31:0] wb_dest_reg = '0;
  logic [63:0] wb_result = '0;
  logic [2:0]  wb_opsize = '0;
  logic [15:0] wb_opcode = '0;
  logic        wb_op_a_is_address = 1'b0;
  logic        wb_op_a_is_reg = 1'b0;
  logic        wb_op_a_is_segment = 1'b0;
  logic        wb_op_a_is_mmx = 1'b0;
  logic        wb_stack = 1'b0;
  logic [1:0]  wb_stack_op = '0;
  logic        wb_to_sys_controller = 1'b0;
  logic [31:0] wb_pc = '0;
  logic        reg_wr_en, seg_wr_en, mmx_wr_en;
  logic [2:0]  reg_wr_idx, reg_wr_size, seg_wr_idx, mmx_wr_idx;
  logic [31:0] reg_wr_data;
  logic [15:0] seg_wr_data;
  logic [63:0] mmx_wr_data;
  logic        mem_req;
  logic [31:0] mem_addr, mem_data;
  logic [2:0]  mem_size;
  logic        mem_ack = 1'b0;
  logic        esp_wr_en;
  logic [31:0] esp_delta;
  logic        sys_req;
  logic [31:0] sys_pc;
  wb_state_e   dbg_state;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  writeback_top dut (
    .clk(clk), .reset(reset), .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dest_address(wb_dest_address), .wb_dest_reg(wb_dest_reg), .wb_result(wb_result),
    .wb_opsize(wb_opsize), .wb_opcode(wb_opcode), .wb_op_a_is_address(wb_op_a_is_address),
    .wb_op_a_is_reg(wb_op_a_is_reg), .wb_op_a_is_segment(wb_op_a_is_segment),
    .wb_op_a_is_mmx(wb_op_a_is_mmx), .wb_stack(wb_stack), .wb_stack_op(wb_stack_op),
    .wb_to_sys_controller(wb_to_sys_controller), .wb_pc(wb_pc),
    .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data), .reg_wr_size(reg_wr_size),
    .seg_wr_en(seg_wr_en), .seg_wr_idx(seg_wr_idx), .seg_wr_data(seg_wr_data),
    .mmx_wr_en(mmx_wr_en), .mmx_wr_idx(mmx_wr_idx), .mmx_wr_data(mmx_wr_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_size(mem_size), .mem_ack(mem_ack),
    .esp_wr_en(esp_wr_en), .esp_delta(esp_delta), .sys_req(sys_req), .sys_pc(sys_pc),
    .dbg_state(dbg_state)
`ifdef WB_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic clear_payload();
    wb_valid = 1'b0; wb_op_a_is_address = 1'b0; wb_op_a_is_reg = 1'b0;
    wb_op_a_is_segment = 1'b0; wb_op_a_is_mmx = 1'b0; wb_to_sys_controller = 1'b0;
    wb_stack = 1'b0; wb_stack_op = STACK_NONE;
  endtask

  task automatic drive_mem(input logic [31:0] addr, input logic [63:0] res,
                           input logic [2:0] op, input logic [1:0] sop);
    clear_payload();
    wb_valid = 1'b1; wb_op_a_is_address = 1'b1; wb_dest_address = addr;
    wb_result = res; wb_opsize = op; wb_stack_op = sop; wb_stack = (sop != STACK_NONE);
    @(negedge clk);
    clear_payload();
  endtask

  task automatic ack_cycle();
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  // Scoreboard
  function automatic logic [W-1:0] ev(input logic [3:0] k, input logic [3:0] i,
                                      input logic [31:0] a, input logic [63:0] d);
    return {k, i, a, d};
  endfunction

  task automatic observe(input string name, input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got event %0h, expected no event", name, got);
    end else begin
      check(name, got, exp_q.pop_front());
    end
  endtask

  task automatic monitor();
    if (reg_wr_en) observe("rnd_reg", ev(4'd1, {1'b0, reg_wr_idx}, {29'd0, reg_wr_size}, {32'd0, reg_wr_data}));
    if (seg_wr_en) observe("rnd_seg", ev(4'd2, {1'b0, seg_wr_idx}, 32'd0, {48'd0, seg_wr_data}));
    if (mmx_wr_en) observe("rnd_mmx", ev(4'd3, {1'b0, mmx_wr_idx}, 32'd0, mmx_wr_data));
    if (sys_req)   observe("rnd_sys", ev(4'd6, 4'd0, sys_pc, 64'd0));
    if (mem_req && mem_ack) observe("rnd_mem", ev(4'd4, {1'b0, mem_size}, mem_addr, {32'd0, mem_data}));
    if (esp_wr_en) observe("rnd_esp", ev(4'd5, 4'd0, 32'd0, {32'd0, esp_delta}));
  endtask

  // Reference model: expected architectural effects of one accepted instruction.
  task automatic model_accept();
    int unsigned bytes;
    logic [31:0] delta;
    logic [2:0]  msz;
    bytes = (wb_opsize == 3'd0) ? 1 : (wb_opsize == 3'd1) ? 2 : (wb_opsize == 3'd3) ? 8 : 4;
    delta = (wb_stack_op == 2'b01) ? (32'd0 - 32'(bytes)) : 32'(bytes);
    msz = (wb_opsize <= 3'd1) ? wb_opsize : 3'd2;
    if (wb_to_sys_controller) begin
      exp_q.push_back(ev(4'd6, 4'd0, wb_pc, 64'd0));
    end else if (wb_op_a_is_address) begin
      exp_q.push_back(ev(4'd4, {1'b0, msz}, wb_dest_address, {32'd0, wb_result[31:0]}));
      if (bytes == 8) exp_q.push_back(ev(4'd4, {1'b0, msz}, wb_dest_address + 32'd4, {32'd0, wb_result[63:32]}));
      if (wb_stack_op == 2'b01 || wb_stack_op == 2'b10) exp_q.push_back(ev(4'd5, 4'd0, 32'd0, {32'd0, delta}));
    end else begin
      if (wb_op_a_is_reg) exp_q.push_back(ev(4'd1, {1'b0, wb_dest_reg[2:0]}, {29'd0, wb_opsize}, {32'd0, wb_result[31:0]}));
      if (wb_op_a_is_segment) exp_q.push_back(ev(4'd2, {1'b0, wb_dest_reg[2:0]}, 32'd0, {48'd0, wb_result[15:0]}));
      if (wb_op_a_is_mmx) exp_q.push_back(ev(4'd3, {1'b0, wb_dest_reg[2:0]}, 32'd0, wb_result));
      if (wb_stack_op == 2'b01 || wb_stack_op == 2'b10) exp_q.push_back(ev(4'd5, 4'd0, 32'd0, {32'd0, delta}));
    end
  endtask

  typedef struct {
    logic        is_reg, is_seg, is_mmx, is_sys;
    logic [1:0]  stack_op;
    logic [2:0]  opsize;
    logic [2:0]  dest;
    logic [63:0] result;
    logic [31:0] pc;
    logic        exp_reg, exp_seg, exp_mmx, exp_sys, exp_esp;
    logic [31:0] exp_delta;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'd2, 3'd3, 64'h0000_0000_1234_5678, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'd1, 3'd5, 64'h0000_0000_1111_BEEF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd3, 3'd7, 64'h0123_4567_89AB_CDEF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'd1, 3'd1, 64'hFFFF_0000_0000_A5A5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'd3, 3'd2, 64'h0000_0001_DEAD_BEEF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 3'd2, 3'd4, 64'h0000_0000_0BAD_F00D, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 3'd2, 3'd6, 64'h0000_0000_0000_0001, 32'h8000_0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'd5, 3'd6, 64'h0000_0000_7777_6666, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0004};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'd0, 3'd0, 64'h0000_0000_CAFE_0042, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF};
  end

  initial begin
    logic        have_instr;
    logic        want_flush;
    int          issued;
    int unsigned r;

    // Reset behaviour
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ready", wb_ready, 1'b0);
    check("reset_state", dbg_state, ST_IDLE);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_enables", {reg_wr_en, seg_wr_en, mmx_wr_en, esp_wr_en, sys_req}, 5'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_reg_data", reg_wr_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", wb_ready, 1'b1);

    // Table of single-cycle destinations
    for (int i = 0; i < 9; i++) begin
      clear_payload();
      wb_valid = 1'b1;
      wb_op_a_is_reg = vecs[i].is_reg; wb_op_a_is_segment = vecs[i].is_seg;
      wb_op_a_is_mmx = vecs[i].is_mmx; wb_to_sys_controller = vecs[i].is_sys;
      wb_stack_op = vecs[i].stack_op; wb_stack = (vecs[i].stack_op != 2'b00);
      wb_opsize = vecs[i].opsize; wb_dest_reg = {29'h0ABC_DEF, vecs[i].dest};
      wb_result = vecs[i].result; wb_pc = vecs[i].pc;
      @(negedge clk);
      clear_payload();
      check("vec_ready", wb_ready, 1'b1);
      check("vec_reg_en", reg_wr_en, vecs[i].exp_reg);
      check("vec_seg_en", seg_wr_en, vecs[i].exp_seg);
      check("vec_mmx_en", mmx_wr_en, vecs[i].exp_mmx);
      check("vec_sys_req", sys_req, vecs[i].exp_sys);
      check("vec_esp_en", esp_wr_en, vecs[i].exp_esp);
      if (vecs[i].exp_reg) begin
        check("vec_reg_idx", reg_wr_idx, vecs[i].dest);
        check("vec_reg_data", reg_wr_data, vecs[i].result[31:0]);
        check("vec_reg_size", reg_wr_size, vecs[i].opsize);
      end
      if (vecs[i].exp_seg) begin
        check("vec_seg_idx", seg_wr_idx, vecs[i].dest);
        check("vec_seg_data", seg_wr_data, vecs[i].result[15:0]);
      end
      if (vecs[i].exp_mmx) begin
        check("vec_mmx_idx", mmx_wr_idx, vecs[i].dest);
        check("vec_mmx_data", mmx_wr_data, vecs[i].result);
      end
      if (vecs[i].exp_sys) check("vec_sys_pc", sys_pc, vecs[i].pc);
      if (vecs[i].exp_esp) check("vec_esp_delta", esp_delta, vecs[i].exp_delta);
    end
    @(negedge clk);
    check("pulse_clears", {reg_wr_en, seg_wr_en, mmx_wr_en, esp_wr_en, sys_req}, 5'd0);

    // 64-bit store split into two words
    drive_mem(32'h0000_1000, 64'hAAAA_BBBB_CCCC_DDDD, OPSIZE_64, STACK_NONE);
    check("m64_req_lo", mem_req, 1'b1);
    check("m64_addr_lo", mem_addr, 32'h0000_1000);
    check("m64_data_lo", mem_data, 32'hCCCC_DDDD);
    check("m64_size", mem_size, 3'd2);
    check("m64_ready_lo", wb_ready, 1'b0);
    @(negedge clk);
    check("m64_hold_req", mem_req, 1'b1);
    ack_cycle();
    check("m64_req_hi", mem_req, 1'b1);
    check("m64_addr_hi", mem_addr, 32'h0000_1004);
    check("m64_data_hi", mem_data, 32'hAAAA_BBBB);
    check("m64_ready_hi", wb_ready, 1'b0);
    ack_cycle();
    check("m64_req_done", mem_req, 1'b0);
    check("m64_ready_done", wb_ready, 1'b1);

    // 32-bit push: single word, esp adjust with the ack
    drive_mem(32'h0000_2000, 64'h0000_0000_0000_0055, OPSIZE_32, STACK_PUSH);
    check("push_req", mem_req, 1'b1);
    mem_ack = 1'b1;
    #1;
    check("push_esp_en", esp_wr_en, 1'b1);
    check("push_esp_delta", esp_delta, 32'hFFFF_FFFC);
    @(negedge clk);
    mem_ack = 1'b0;
    check("push_req_done", mem_req, 1'b0);
    check("push_esp_clear", esp_wr_en, 1'b0);
    check("push_ready", wb_ready, 1'b1);

    // Flush during the low word of a 64-bit push
    drive_mem(32'h0000_1000, 64'hAAAA_BBBB_CCCC_DDDD, OPSIZE_64, STACK_PUSH);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_req_held", mem_req, 1'b1);
    check("flush_addr_lo", mem_addr, 32'h0000_1000);
    mem_ack = 1'b1;
    #1;
    check("flush_no_esp", esp_wr_en, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
    check("flush_no_hi", mem_req, 1'b0);
    check("flush_ready", wb_ready, 1'b1);
    @(negedge clk);
    check("flush_still_idle", mem_req, 1'b0);

    // Address wrap on the high word, pop of 8 bytes
    drive_mem(32'hFFFF_FFFC, 64'h1111_2222_3333_4444, OPSIZE_64, STACK_POP);
    check("wrap_addr_lo", mem_addr, 32'hFFFF_FFFC);
    ack_cycle();
    check("wrap_addr_hi", mem_addr, 32'h0000_0000);
    check("wrap_data_hi", mem_data, 32'h1111_2222);
    mem_ack = 1'b1;
    #1;
    check("wrap_esp_en", esp_wr_en, 1'b1);
    check("wrap_esp_delta", esp_delta, 32'h0000_0008);
    @(negedge clk);
    mem_ack = 1'b0;
    check("wrap_req_done", mem_req, 1'b0);

    // Reset while in the high word; a late ack must be ignored
    drive_mem(32'h0000_3000, 64'h5555_6666_7777_8888, OPSIZE_64, STACK_NONE);
    ack_cycle();
    check("rst_in_hi_addr", mem_addr, 32'h0000_3004);
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_drop", mem_req, 1'b0);
    check("rst_ready_low", wb_ready, 1'b0);
    mem_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_release_ready", wb_ready, 1'b1);
    @(negedge clk);
    mem_ack = 1'b0;
    check("rst_late_ack_req", mem_req, 1'b0);
    check("rst_late_ack_esp", esp_wr_en, 1'b0);
    check("rst_late_ack_ready", wb_ready, 1'b1);

    // Flush with valid in the same idle cycle drops the transfer
    clear_payload();
    wb_valid = 1'b1; wb_op_a_is_reg = 1'b1; wb_stack_op = STACK_PUSH; wb_result = 64'h99;
    flush = 1'b1;
    @(negedge clk);
    clear_payload();
    flush = 1'b0;
    check("flush_valid_reg", reg_wr_en, 1'b0);
    check("flush_valid_esp", esp_wr_en, 1'b0);

    // Randomized traffic against the reference model
    have_instr = 1'b0;
    want_flush = 1'b0;
    issued = 0;
    for (int cyc = 0; cyc < 4000 && issued < 300; cyc++) begin
      @(negedge clk);
      if (!have_instr) begin
        clear_payload();
        flush = 1'b0;
        if ($urandom_range(0, 9) < 7) begin
          r = $urandom_range(0, 9);
          wb_valid = 1'b1;
          wb_to_sys_controller = (r == 0);
          wb_op_a_is_address = (r >= 1 && r <= 4) ? 1'b1 : 1'($urandom_range(0, 1) & (r == 0));
          wb_op_a_is_reg = 1'($urandom_range(0, 1));
          wb_op_a_is_segment = 1'($urandom_range(0, 1));
          wb_op_a_is_mmx = 1'($urandom_range(0, 1));
          wb_stack = 1'($urandom_range(0, 1));
          wb_stack_op = 2'($urandom_range(0, 3));
          wb_opsize = 3'($urandom_range(0, 7));
          wb_dest_reg = $urandom;
          wb_dest_address = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
          wb_result = {$urandom, $urandom};
          wb_opcode = 16'($urandom);
          wb_pc = $urandom;
          want_flush = ($urandom_range(0, 15) == 0);
          have_instr = 1'b1;
        end
      end
      flush = have_instr && want_flush && wb_ready;
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      monitor();
      if (wb_valid && wb_ready) begin
        if (!flush) model_accept();
        have_instr = 1'b0;
        issued++;
      end
    end

    // Drain outstanding work
    @(negedge clk);
    clear_payload();
    flush = 1'b0;
    for (int cyc = 0; cyc < 50 && (exp_q.size() != 0 || mem_req); cyc++) begin
      mem_ack = 1'b1;
      #1;
      monitor();
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("rnd_issued", issued, 300);
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_final_idle", wb_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/writeback_top.md
WRITEBACK_TOP -- requirements
Module: writeback_top

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high.
REQ-003 SHALL: flush  in  1  synchronous pipeline flush.
REQ-004 SHALL: wb_valid  in  1 / wb_ready  out  1  consumer end of the execute pipestage; transfer when both high.
REQ-005 SHALL: wb_dest_address in 32, wb_dest_reg in 32 (bits [2:0] used), wb_result in 64, wb_opsize in 3, wb_opcode in 16  payload.
REQ-006 SHALL: wb_op_a_is_address, wb_op_a_is_reg, wb_op_a_is_segment, wb_op_a_is_mmx, wb_stack in 1 each; wb_stack_op in 2; wb_to_sys_controller in 1; wb_pc in 32  destination class/control.
REQ-007 SHALL: reg_wr_en out 1, reg_wr_idx out 3, reg_wr_data out 32, reg_wr_size out 3  GPR write port; seg_wr_en out 1, seg_wr_idx out 3, seg_wr_data out 16; mmx_wr_en out 1, mmx_wr_idx out 3, mmx_wr_data out 64.
REQ-008 SHALL: mem_req out 1, mem_addr out 32, mem_data out 32, mem_size out 3, mem_ack in 1  data-memory write port; request held until ack.
REQ-009 SHALL: esp_wr_en out 1, esp_delta out 32 (two's complement)  stack-pointer adjust; sys_req out 1, sys_pc out 32  system-controller hand-off.

Function
REQ-010 SHALL: wb_opsize encoding 0=8b, 1=16b, 2=32b, 3=64b; other values treated as 32b.
REQ-011 SHALL: FSM states IDLE, MEM_LO, MEM_HI; wb_ready = 1 only in IDLE and not reset.
REQ-012 SHALL: on transfer in IDLE, all payload captured into registers; outputs derive only from captured copy.
REQ-013 SHALL: register, segment, MMX destinations -> corresponding *_wr_en high exactly one cycle after transfer, FSM stays IDLE (throughput 1/cycle).
REQ-014 SHALL: reg_wr_data = wb_result[31:0]; seg_wr_data = wb_result[15:0]; mmx_wr_data = wb_result[63:0]; idx = wb_dest_reg[2:0].
REQ-015 SHALL: memory destination -> IDLE->MEM_LO; mem_req high from next cycle with mem_addr = wb_dest_address, mem_data = wb_result[31:0], mem_size = min(opsize,2).
REQ-016 SHALL: in MEM_LO on mem_ack: opsize 64b -> MEM_HI with mem_addr+4, mem_data = wb_result[63:32]; else -> IDLE; mem_req drops the cycle after ack.
REQ-017 SHALL: in MEM_HI on mem_ack -> IDLE.
REQ-018 SHALL: address add wraps modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-019 SHALL: wb_stack_op 01 push -> esp_delta = -(bytes), 10 pop -> +(bytes), 00/11 -> no esp_wr_en; esp_wr_en pulses one cycle, issued with the register write or with the final mem_ack.
REQ-020 SHALL: wb_to_sys_controller -> sys_req one-cycle pulse, sys_pc = wb_pc, no architectural write.
REQ-021 SHALL: flush in IDLE drops captured transfer (no write pulses next cycle); flush in MEM_LO/MEM_HI keeps mem_req until current ack, skips MEM_HI, suppresses esp_wr_en, returns IDLE.
REQ-022 SHALL: flush and wb_valid in same IDLE cycle -> transfer ignored.

Reset
REQ-023 SHALL: reset -> state IDLE; all *_wr_en, mem_req, esp_wr_en, sys_req = 0; data/address outputs = 0; wb_ready = 0 during reset, 1 the cycle after.
REQ-024 SHALL: reset mid-MEM_LO/MEM_HI abandons transaction immediately; late mem_ack ignored.

Configuration
REQ-025 SHALL: WB_RETIRE_COUNT_EN defined -> extra output retire_count out 32, +1 per completed non-flushed instruction, wraps, reset 0; undefined -> port and counter absent, behaviour otherwise identical.

Structure
REQ-026 SHALL: shared package holds opsize codes, stack_op codes, FSM state encoding.
REQ-027 SHALL: one sub-module wb_mem_seq (MEM_LO/MEM_HI sequencer and address increment); remainder in writeback_top.

Verification
REQ-028 SHALL: reg write: dest_reg=3, result=0x12345678, opsize 2 -> next cycle reg_wr_en=1, idx=3, data=0x12345678; wb_ready stays 1.
REQ-029 SHALL: 64b mem: addr 0x1000, result 0xAAAA_BBBB_CCCC_DDDD -> writes 0xCCCCDDDD@0x1000 then 0xAAAABBBB@0x1004; wb_ready 0 until second ack.
REQ-030 SHALL: push 32b mem -> single write, esp_wr_en with esp_delta=0xFFFFFFFC at ack.
REQ-031 SHALL: flush during MEM_LO of 64b write -> no 0x1004 request, no esp_wr_en, IDLE after ack.
REQ-032 SHALL: addr 0xFFFFFFFC 64b -> second write to 0x00000000.
REQ-033 SHALL: reset asserted in MEM_HI -> mem_req 0 next cycle, wb_ready 1 after release.
